// File: rtl/alu_mc_if.sv
// Valid/ready bundle between an operand producer, alu_mc and a result consumer.
// master = producer/consumer side, slave = the ALU.
interface alu_mc_if #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op_code;
    logic [WORD_W-1:0] d_in0;
    logic [WORD_W-1:0] d_in1;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] d_out;
    logic [WORD_W-1:0] d_out_hi;
    logic [3:0]        flags;

    modport master (
        output in_valid, op_code, d_in0, d_in1, out_ready,
        input  in_ready, out_valid, d_out, d_out_hi, flags
    );

    modport slave (
        input  in_valid, op_code, d_in0, d_in1, out_ready,
        output in_ready, out_valid, d_out, d_out_hi, flags
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready handshake, carry-chained ADC/SBC, registered NZCV flags.
// Define ALU_MUL_EN to build the iterative MULU (opcode 13); otherwise opcode 13 is illegal.
module alu_mc #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 6,
    parameter int SH_W   = $clog2(WORD_W)
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);
    localparam int MSB = WORD_W - 1;

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOTA  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHR   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SAR   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_PASSA = OP_W'(9);
    localparam logic [OP_W-1:0] OP_PASSB = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADC   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SBC   = OP_W'(12);

    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              accept;
    logic              wr_single;
    logic              c_prev;
    logic              carry_in;
    logic [WORD_W:0]   sum;
    logic [WORD_W-1:0] res;
    logic              res_c;
    logic              res_v;

    logic              out_valid_q;
    logic [WORD_W-1:0] d_out_q;
    logic [3:0]        flags_q;

    assign op_a   = bus.d_in0;
    assign op_b   = bus.d_in1;
    assign c_prev = flags_q[1];
    assign accept = bus.in_valid && bus.in_ready;

    // Single-cycle datapath; unlisted opcodes fall to the default and give the illegal result.
    always_comb begin
        res      = '0;
        sum      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        carry_in = 1'b0;
        case (bus.op_code)
            OP_ADD, OP_ADC: begin
                carry_in = (bus.op_code == OP_ADC) && c_prev;
                sum   = {1'b0, op_a} + {1'b0, op_b} + {{WORD_W{1'b0}}, carry_in};
                res   = sum[WORD_W-1:0];
                res_c = sum[WORD_W];
                res_v = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                carry_in = (bus.op_code == OP_SBC) && !c_prev;
                sum   = {1'b0, op_a} - {1'b0, op_b} - {{WORD_W{1'b0}}, carry_in};
                res   = sum[WORD_W-1:0];
                res_c = !sum[WORD_W];
                res_v = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
            end
            OP_AND:   res = op_a & op_b;
            OP_OR:    res = op_a | op_b;
            OP_XOR:   res = op_a ^ op_b;
            OP_NOTA:  res = ~op_a;
            OP_SHL:   res = op_a << op_b[SH_W-1:0];
            OP_SHR:   res = op_a >> op_b[SH_W-1:0];
            OP_SAR:   res = $unsigned($signed(op_a) >>> op_b[SH_W-1:0]);
            OP_PASSA: res = op_a;
            OP_PASSB: res = op_b;
            default:  res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [OP_W-1:0] OP_MULU = OP_W'(13);
    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_W-1:0]   mcand;
    logic [2*WORD_W-1:0] acc;
    logic [2*WORD_W-1:0] acc_nxt;
    logic [WORD_W:0]     hi_sum;
    logic                mul_last;
    logic [WORD_W-1:0]   d_hi_q;

    assign wr_single    = accept && (bus.op_code != OP_MULU);
    assign bus.in_ready = (state == S_IDLE) && (!out_valid_q || bus.out_ready) && rst_n;
    assign bus.d_out_hi = d_hi_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Shift-add step: the multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        state_nxt = state;
        mul_last  = 1'b0;
        hi_sum    = {1'b0, acc[2*WORD_W-1:WORD_W]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_nxt   = {hi_sum, acc[WORD_W-1:1]};
        case (state)
            S_IDLE: if (accept && (bus.op_code == OP_MULU)) state_nxt = S_MUL;
            S_MUL: begin
                mul_last = (cnt == CNT_W'(WORD_W - 1));
                if (mul_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (accept && (bus.op_code == OP_MULU)) begin
            cnt   <= '0;
            mcand <= op_a;
            acc   <= {{WORD_W{1'b0}}, op_b};
        end else if (state == S_MUL) begin
            cnt   <= cnt + CNT_W'(1);
            acc   <= acc_nxt;
        end
    end
`else
    assign wr_single    = accept;
    assign bus.in_ready = (!out_valid_q || bus.out_ready) && rst_n;
    assign bus.d_out_hi = '0;
`endif

    // Result registers hold until retired; a new write on the retire edge keeps out_valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            d_out_q     <= '0;
            flags_q     <= '0;
`ifdef ALU_MUL_EN
            d_hi_q      <= '0;
`endif
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            if (wr_single) begin
                out_valid_q <= 1'b1;
                d_out_q     <= res;
                flags_q     <= {res[MSB], res == '0, res_c, res_v};
`ifdef ALU_MUL_EN
                d_hi_q      <= '0;
`endif
            end
`ifdef ALU_MUL_EN
            if (mul_last) begin
                out_valid_q <= 1'b1;
                d_out_q     <= acc_nxt[WORD_W-1:0];
                d_hi_q      <= acc_nxt[2*WORD_W-1:WORD_W];
                flags_q     <= {acc_nxt[2*WORD_W-1], acc_nxt == '0,
                                acc_nxt[2*WORD_W-1:WORD_W] != '0, 1'b0};
            end
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.d_out     = d_out_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WORD_W=8): vector table plus scoreboard, and hand sequences for backpressure,
// reset and latency. MULU sequences are built only with ALU_MUL_EN; otherwise opcode 13 is illegal.
module tb_alu_mc;
    localparam int NV = 21;

    typedef struct packed {
        logic [7:0] d_out;
        logic [7:0] d_hi;
        logic [3:0] flags;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_accept = 0;
    exp_t expq[$];
    exp_t mon_e;
    vec_t vecs[NV];

    alu_mc_if #(.WORD_W(8), .OP_W(6)) bus ();

    alu_mc #(.WORD_W(8), .OP_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard: every retiring result is compared against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result",
                         {bus.d_out, bus.d_out_hi, bus.flags});
            end else begin
                mon_e = expq.pop_front();
                checkOutput("result", {12'b0, bus.d_out, bus.d_out_hi, bus.flags}, {12'b0, mon_e});
            end
        end
    end

    function automatic exp_t mke(input logic [7:0] d, input logic [7:0] h, input logic [3:0] f);
        exp_t e;
        e.d_out = d;
        e.d_hi  = h;
        e.flags = f;
        return e;
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] d, input logic [3:0] f);
        vec_t v;
        v.op = op;
        v.a  = a;
        v.b  = b;
        v.e  = mke(d, 8'h00, f);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; leaves in_valid high so callers can stream operations.
    task automatic applyStimulus(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.op_code  = op;
        bus.d_in0    = a;
        bus.d_in1    = b;
        @(negedge clk);
        while (!bus.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            bus.in_valid = 1'b0;
            $display("[TB] FAIL accept_timeout: in_ready 0 for %0d cycles, expected 1", waited);
        end else begin
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        last_accept = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("drain", expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_acc;
        int rel_cyc;
        bus.in_valid  = 1'b0;
        bus.op_code   = '0;
        bus.d_in0     = '0;
        bus.d_in1     = '0;
        bus.out_ready = 1'b1;

        vecs[0]  = mk(6'd0,  8'h7F, 8'h01, 8'h80, 4'b1001);
        vecs[1]  = mk(6'd1,  8'h05, 8'h05, 8'h00, 4'b0110);
        vecs[2]  = mk(6'd12, 8'h10, 8'h01, 8'h0F, 4'b0010);
        vecs[3]  = mk(6'd1,  8'h00, 8'h01, 8'hFF, 4'b1000);
        vecs[4]  = mk(6'd11, 8'hFF, 8'h01, 8'h00, 4'b0110);
        vecs[5]  = mk(6'd11, 8'h01, 8'h01, 8'h03, 4'b0000);
        vecs[6]  = mk(6'd12, 8'h80, 8'h01, 8'h7E, 4'b0011);
        vecs[7]  = mk(6'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000);
        vecs[8]  = mk(6'd3,  8'h0F, 8'h80, 8'h8F, 4'b1000);
        vecs[9]  = mk(6'd4,  8'hF0, 8'hFF, 8'h0F, 4'b0000);
        vecs[10] = mk(6'd5,  8'h55, 8'h00, 8'hAA, 4'b1000);
        vecs[11] = mk(6'd6,  8'h81, 8'h09, 8'h02, 4'b0000);
        vecs[12] = mk(6'd7,  8'h81, 8'h04, 8'h08, 4'b0000);
        vecs[13] = mk(6'd8,  8'h81, 8'h04, 8'hF8, 4'b1000);
        vecs[14] = mk(6'd8,  8'h40, 8'h07, 8'h00, 4'b0100);
        vecs[15] = mk(6'd9,  8'hA5, 8'h3C, 8'hA5, 4'b1000);
        vecs[16] = mk(6'd10, 8'hA5, 8'h3C, 8'h3C, 4'b0000);
        vecs[17] = mk(6'd14, 8'h12, 8'h34, 8'h00, 4'b0100);
        vecs[18] = mk(6'd63, 8'h12, 8'h34, 8'h00, 4'b0100);
        vecs[19] = mk(6'd0,  8'hFF, 8'hFF, 8'hFE, 4'b1010);
        vecs[20] = mk(6'd1,  8'h7F, 8'hFF, 8'h80, 4'b1001);

        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_state", {bus.out_valid, bus.in_ready, bus.d_out, bus.d_out_hi, bus.flags}, 32'h0);
        tick();
        rst_n   = 1'b1;
        rel_cyc = cyc;

        first_acc = 0;
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
            if (i == 0) begin
                checkOutput("first_accept_after_reset", last_accept - rel_cyc, 1);
                first_acc = last_accept;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("throughput", last_accept - first_acc, NV - 1);
        drain();

        applyStimulus(6'd0, 8'h01, 8'h01, mke(8'h02, 8'h00, 4'b0000));
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("single_latency", bus.out_valid, 1);
        tick();
        drain();

        // Backpressure: result held three cycles while an XOR waits, then retire and accept together.
        bus.out_ready = 1'b0;
        applyStimulus(6'd9, 8'h5A, 8'h00, mke(8'h5A, 8'h00, 4'b0000));
        bus.op_code  = 6'd4;
        bus.d_in0    = 8'hF0;
        bus.d_in1    = 8'hFF;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_hold", {bus.out_valid, bus.in_ready, bus.d_out, bus.d_out_hi, bus.flags},
                        {1'b1, 1'b0, 8'h5A, 8'h00, 4'b0000});
            tick();
        end
        bus.out_ready = 1'b1;
        rel_cyc = cyc;
        applyStimulus(6'd4, 8'hF0, 8'hFF, mke(8'h0F, 8'h00, 4'b0000));
        bus.in_valid = 1'b0;
        checkOutput("retire_accept_same_edge", last_accept - rel_cyc, 1);
        @(negedge clk);
        checkOutput("xor_next_cycle", {bus.out_valid, bus.d_out}, {1'b1, 8'h0F});
        tick();
        drain();

`ifdef ALU_MUL_EN
        applyStimulus(6'd13, 8'hFF, 8'hFF, mke(8'h01, 8'hFE, 4'b1010));
        bus.in_valid = 1'b0;
        bus.d_in0    = 8'h00;
        bus.d_in1    = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput("mul_busy", {bus.out_valid, bus.in_ready}, 2'b00);
        end
        @(negedge clk);
        checkOutput("mul_done_latency", bus.out_valid, 1);
        tick();
        drain();

        applyStimulus(6'd13, 8'h00, 8'h37, mke(8'h00, 8'h00, 4'b0100));
        applyStimulus(6'd13, 8'h0D, 8'h0B, mke(8'h8F, 8'h00, 4'b0000));
        applyStimulus(6'd13, 8'h80, 8'h02, mke(8'h00, 8'h01, 4'b0010));
        bus.in_valid = 1'b0;
        drain();

        // Abort a multiply: reset asserted during its fourth cycle.
        applyStimulus(6'd13, 8'h03, 8'h05, mke(8'h0F, 8'h00, 4'b0000));
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("mul_abort_reset",
                    {bus.out_valid, bus.in_ready, bus.d_out, bus.d_out_hi, bus.flags}, 32'h0);
        tick();
        rst_n = 1'b1;
        expq.delete();
        @(negedge clk);
        checkOutput("ready_after_abort", bus.in_ready, 1);
        tick();
        applyStimulus(6'd0, 8'h01, 8'h01, mke(8'h02, 8'h00, 4'b0000));
        bus.in_valid = 1'b0;
        drain();
`else
        applyStimulus(6'd13, 8'h03, 8'h04, mke(8'h00, 8'h00, 4'b0100));
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("op13_illegal_latency", bus.out_valid, 1);
        tick();
        drain();
`endif

        // Reset while a result is held unretired clears everything.
        bus.out_ready = 1'b0;
        applyStimulus(6'd10, 8'h00, 8'hC3, mke(8'hC3, 8'h00, 4'b1000));
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("held_before_reset", {bus.out_valid, bus.d_out, bus.flags}, {1'b1, 8'hC3, 4'b1000});
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("reset_clears_held",
                    {bus.out_valid, bus.in_ready, bus.d_out, bus.d_out_hi, bus.flags}, 32'h0);
        expq.delete();
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(6'd1, 8'h09, 8'h03, mke(8'h06, 8'h00, 4'b0010));
        bus.in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
